block_lock_ctrl: RTL
====================

# block_lock_ctrl

Block-lock controller for the 66b receive path. It watches the 2-bit sync headers delivered by the header seeker/gearbox, declares block lock after a run of valid headers, and drops lock when too many invalid headers arrive within a window. While unlocked it issues single-cycle slip commands that step the upstream block-offset search by one position. It sits between the header seeker and the downstream descrambler/decoder, which qualify their data with `locked_o`.

## Interface

Parameters
- `LOCK_CNT`, 64: consecutive valid headers required to declare lock (>= 2).
- `WINDOW`, 1024: header window length while locked (> `UNLOCK_BAD`).
- `UNLOCK_BAD`, 16: invalid headers within one window that drop lock (>= 1).
- `SLIP_WAIT`, 16: clock cycles after a slip during which headers are ignored (>= 1).

Ports
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  controller enable; low forces UNLOCKED with all counters clear.
- `hdr_dv_i`  in  1  `hdr_i` valid strobe, one per 66b block.
- `hdr_i`  in  2  sync header. `2'b01` (data) and `2'b10` (cmd) are valid; `00` and `11` are invalid.
- `slip_o`  out  1  one-cycle pulse requesting an offset step of one position.
- `locked_o`  out  1  block lock status.
- `state_o`  out  2  current state: 0 UNLOCKED, 1 SLIP_WAIT, 2 LOCKED.
- `slip_cnt_o`  out  16  saturating slip count. Present only with the macro.
- `lock_loss_cnt_o`  out  16  saturating lock-loss count. Present only with the macro.

## Operation

- Internal counters:
  - `good_cnt`: `$clog2(LOCK_CNT+1)` bits.
  - `win_cnt`: `$clog2(WINDOW+1)` bits.
  - `bad_cnt`: `$clog2(UNLOCK_BAD+1)` bits.
  - `wait_cnt`: `$clog2(SLIP_WAIT+1)` bits.
  - All counters are unsigned and never wrap; each is cleared at the transition that ends its use.
- UNLOCKED
  - Valid `hdr_i` with `hdr_dv_i`: `good_cnt`++.
  - On the `LOCK_CNT`-th consecutive valid header: go to LOCKED and clear all counters.
  - Invalid header: clear `good_cnt`, pulse `slip_o`, go to SLIP_WAIT.
- SLIP_WAIT
  - `wait_cnt` increments every clock; `hdr_dv_i` is ignored.
  - When `wait_cnt` reaches `SLIP_WAIT - 1`: go to UNLOCKED and clear `wait_cnt`.
- LOCKED
  - Each `hdr_dv_i` increments `win_cnt`; each invalid header also increments `bad_cnt`.
  - If `bad_cnt` reaches `UNLOCK_BAD`: drop `locked_o`, pulse `slip_o`, go to SLIP_WAIT, clear counters.
  - Otherwise, when `win_cnt` reaches `WINDOW`: clear both `win_cnt` and `bad_cnt`, stay LOCKED.
  - If the `UNLOCK_BAD`-th bad header is also the `WINDOW`-th header, unlock has priority.
- `en_i` low, in any state: the next state is UNLOCKED, all counters clear, `locked_o` = 0, no slip is issued. Statistics counters are not affected.
- `hdr_dv_i` low: counters other than `wait_cnt` hold.

## Timing

- Reset values: `slip_o` = 0, `locked_o` = 0, `state_o` = 0 (UNLOCKED), all counters 0, stats = 0.
- All outputs are registered; the header path has one cycle of latency.
  - `slip_o` is high exactly in the cycle after the offending `hdr_dv_i` cycle.
  - `locked_o` rises the cycle after the `LOCK_CNT`-th valid header.
  - `locked_o` falls in the same cycle as the lock-loss `slip_o`.
- `slip_o` is never high on two consecutive cycles. Minimum spacing between slips is `SLIP_WAIT + 1` cycles.
- Headers arriving on the cycle `slip_o` is high are ignored (state is already SLIP_WAIT).
- Asserting `rst_ni` mid-operation returns everything to reset values immediately. This includes killing an in-flight `slip_o`.

## Configuration

- `BLOCK_LOCK_CTRL_STATS_EN` defined:
  - Adds the ports `slip_cnt_o` and `lock_loss_cnt_o`.
  - `slip_cnt_o` increments on every `slip_o` pulse.
  - `lock_loss_cnt_o` increments on every LOCKED→SLIP_WAIT transition.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan

- Lock acquisition: after reset, 64 valid headers (alternating 01/10) → `locked_o` rises 1 cycle after the 64th; `slip_o` never pulses.
- Slip search: invalid header `2'b11` at header 10 while UNLOCKED → `slip_o` pulse 1 cycle later; the next 16 cycles of headers are ignored; lock then needs 64 fresh valid headers.
- Lock loss: while LOCKED, 16 `2'b00` headers within 1024 → `locked_o` falls together with a `slip_o` pulse after the 16th; `lock_loss_cnt_o` = 1 with the macro.
- Window reset: while LOCKED, 15 bad headers in each of 3 consecutive 1024-header windows → lock is held throughout; `bad_cnt` clears at each window end.
- Boundary: 16th bad header arrives as the 1024th header of the window → unlock wins; `slip_o` pulses.
- Reset/enable: drop `rst_ni` mid-SLIP_WAIT, then drop `en_i` while LOCKED → all outputs return to 0; with `en_i` low, invalid headers produce no `slip_o`.

Source files
------------

// File: rtl/block_lock_ctrl.sv
// 66b block-lock controller: acquires lock on a run of valid sync headers, drops it on too many bad
// headers per window, and pulses slip_o while searching. Optional stats via BLOCK_LOCK_CTRL_STATS_EN.
module block_lock_ctrl #(
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 1024,
  parameter int UNLOCK_BAD = 16,
  parameter int SLIP_WAIT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        hdr_dv_i,
  input  logic [1:0]  hdr_i,
  output logic        slip_o,
  output logic        locked_o,
  output logic [1:0]  state_o
`ifdef BLOCK_LOCK_CTRL_STATS_EN
  ,
  output logic [15:0] slip_cnt_o,
  output logic [15:0] lock_loss_cnt_o
`endif
);

  localparam int GW  = $clog2(LOCK_CNT + 1);
  localparam int WW  = $clog2(WINDOW + 1);
  localparam int BW  = $clog2(UNLOCK_BAD + 1);
  localparam int SW  = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_BAD - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [SW-1:0] wait_q, wait_d;
  logic          slip_q, slip_d;
  logic          locked_q, locked_d;
  logic          loss_d;
  logic          hdr_ok;

  // Only 01 (data) and 10 (control) are legal sync headers.
  assign hdr_ok = hdr_i[1] ^ hdr_i[0];

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;
    wait_d   = wait_q;
    slip_d   = 1'b0;
    locked_d = locked_q;
    loss_d   = 1'b0;
    if (!en_i) begin
      state_d  = ST_UNLOCKED;
      good_d   = '0;
      win_d    = '0;
      bad_d    = '0;
      wait_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          if (hdr_dv_i) begin
            if (!hdr_ok) begin
              good_d  = '0;
              slip_d  = 1'b1;
              state_d = ST_SLIP_WAIT;
            end else if (good_q == GOOD_LAST) begin
              good_d   = '0;
              locked_d = 1'b1;
              state_d  = ST_LOCKED;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            state_d = ST_UNLOCKED;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (hdr_dv_i) begin
            // Unlock is checked first so it wins when the last bad header closes the window.
            if (!hdr_ok && (bad_q == BAD_LAST)) begin
              win_d    = '0;
              bad_d    = '0;
              slip_d   = 1'b1;
              locked_d = 1'b0;
              loss_d   = 1'b1;
              state_d  = ST_SLIP_WAIT;
            end else if (win_q == WIN_LAST) begin
              win_d = '0;
              bad_d = '0;
            end else begin
              win_d = win_q + 1'b1;
              bad_d = bad_q + BW'(!hdr_ok);
            end
          end
        end
        default: begin
          state_d  = ST_UNLOCKED;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_UNLOCKED;
      good_q   <= '0;
      win_q    <= '0;
      bad_q    <= '0;
      wait_q   <= '0;
      slip_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      win_q    <= win_d;
      bad_q    <= bad_d;
      wait_q   <= wait_d;
      slip_q   <= slip_d;
      locked_q <= locked_d;
    end
  end

  assign slip_o   = slip_q;
  assign locked_o = locked_q;
  assign state_o  = state_q;

`ifdef BLOCK_LOCK_CTRL_STATS_EN
  logic [15:0] slip_cnt_q, slip_cnt_d;
  logic [15:0] loss_cnt_q, loss_cnt_d;

  // Counted alongside the pulse itself so the count and slip_o update together.
  always_comb begin
    slip_cnt_d = slip_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if (slip_d && (slip_cnt_q != 16'hFFFF)) slip_cnt_d = slip_cnt_q + 16'd1;
    if (loss_d && (loss_cnt_q != 16'hFFFF)) loss_cnt_d = loss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slip_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      slip_cnt_q <= slip_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign slip_cnt_o      = slip_cnt_q;
  assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule
